branch_predictor: RTL and testbench
===================================

# branch_predictor

Dynamic branch predictor for the 5-stage pipeline. It is indexed by the PC of the branch in ID and produces the taken/not-taken prediction that drives early redirect and flush. It resolves the branch in EX against the actual outcome, raises the mispredict flag consumed by the flush/redirect logic, and trains a table of 2-bit saturating counters. It sits directly upstream of the flush/PC-select block and feeds it `predict_o` and `predictWrong_o`.

## Interface
- `ENTRIES`, 16: number of 2-bit counters; power of two, ≥2; `IDX_W = $clog2(ENTRIES)`
- `RESET_STATE`, 2'b11: counter value loaded on reset (strongly taken)

Ports:
- `clk_i`  in  1  clock, rising edge
- `rst_i`  in  1  asynchronous, active-low reset
- `ID_branch_i`  in  1  instruction in ID is a conditional branch
- `ID_pc_i`  in  32  PC of the ID instruction
- `predict_o`  out  1  prediction for the ID branch; 1 = taken; 0 when `ID_branch_i`=0
- `EX_branch_i`  in  1  instruction in EX is a conditional branch (bubbles deassert it)
- `EX_pc_i`  in  32  PC of the EX branch
- `EX_taken_i`  in  1  actual branch outcome computed in EX
- `EX_predict_i`  in  1  prediction carried down the ID/EX register
- `predictWrong_o`  out  1  EX branch was mispredicted

## Operation
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T; predict taken iff bit[1]=1.
- Lookup (combinational): `idx_rd = ID_pc_i[IDX_W+1:2]`; `predict_o = ID_branch_i & cnt[idx_rd][1]`.
- Resolve (combinational): `predictWrong_o = EX_branch_i & (EX_predict_i ^ EX_taken_i)`.
- Update (clocked, only when `EX_branch_i`=1): `idx_wr = EX_pc_i[IDX_W+1:2]`; taken → saturating increment (11 stays 11); not taken → saturating decrement (00 stays 00).
- Transitions: 00↔01↔10↔11 by one step per resolved branch; no other state changes.
- Table state changes only on EX resolution; ID lookups never modify state.
- A flushed ID branch never reaches EX as a branch, so it never trains the table.

## Timing
- Lookup latency: 0 cycles (same-cycle `predict_o`). Resolve latency: 0 cycles. Update is visible at the next rising edge.
- Same-cycle read/write of the same index: the lookup returns the pre-update value. There is no bypass.
- Reset (any time, including mid-stream): all counters are set to `RESET_STATE`, and the history register (if present) is cleared to 0. Outputs are purely combinational from inputs and state, so after reset `predict_o` = `ID_branch_i & RESET_STATE[1]`. With both branch inputs at 0, `predict_o`=0 and `predictWrong_o`=0.
- PC bits [1:0] and bits above IDX_W+1 are ignored. Aliasing between branches is permitted.

## Configuration
- `BP_GSHARE_EN` defined: adds an `IDX_W`-bit global history register `ghr`. Both read and write indices are XORed with `ghr`. On each EX resolve, `ghr <= {ghr[IDX_W-2:0], EX_taken_i}`, updated on the same edge as the counter. The read index uses the current (pre-shift) `ghr`. The history is non-speculative and trained from EX only.
- `BP_GSHARE_EN` undefined: the index is PC-only and no history register exists.

## Structure
- Package `bp_pkg`: counter typedef (2-bit), encoding constants `BP_SNT/BP_WNT/BP_WT/BP_ST`, and the default `ENTRIES`.
- One sub-module, `bp_sat_counter`, is natural: combinational 2-bit next-state logic (inputs: current value, taken; output: next value). It is instanced once on the write path.
- The counter array is a flop array in the top module; no SRAM.

## Test plan
- Reset then lookup: assert `rst_i`=0 then release; `ID_branch_i`=1, `ID_pc_i`=0x40 → `predict_o`=1. `ID_branch_i`=0 → `predict_o`=0.
- Train down: resolve PC 0x40 not-taken three times (`EX_predict_i`=1) → `predictWrong_o`=1 each cycle. Counter steps 11→10→01→00, and the next lookup of 0x40 gives `predict_o`=0.
- Saturation: resolve PC 0x40 not-taken two more times → counter stays 00. Resolve taken twice → 01→10, and lookup gives 1.
- Same-cycle hazard: lookup and not-taken resolve of PC 0x44 while its counter is 10 → `predict_o`=1 that cycle and 0 the next.
- Aliasing/isolation: with `ENTRIES`=16, training PC 0x80 affects PC 0xC0 (same index) but not PC 0x84.
- Mid-stream reset: after training 0x40 to 00, pulse `rst_i` low asynchronously between edges → counters immediately return to 11, and the lookup gives 1 before the next clock edge.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared types and constants for the 2-bit saturating-counter branch predictor.
package bp_pkg;

  typedef logic [1:0] bp_cnt_t;

  localparam bp_cnt_t BP_SNT = 2'b00;
  localparam bp_cnt_t BP_WNT = 2'b01;
  localparam bp_cnt_t BP_WT  = 2'b10;
  localparam bp_cnt_t BP_ST  = 2'b11;

  localparam int BP_ENTRIES = 16;

endpackage

// File: rtl/bp_sat_counter.sv
// Next-state logic for one 2-bit saturating counter: step toward taken or not-taken,
// holding at the strong ends.
module bp_sat_counter
  import bp_pkg::*;
(
  input  bp_cnt_t cnt,
  input  logic    taken,
  output bp_cnt_t cnt_next
);

  bp_cnt_t next_s;

  // One step along SNT <-> WNT <-> WT <-> ST, saturating at both ends
  always_comb begin
    next_s = cnt;
    case (cnt)
      BP_SNT:  next_s = taken ? BP_WNT : BP_SNT;
      BP_WNT:  next_s = taken ? BP_WT  : BP_SNT;
      BP_WT:   next_s = taken ? BP_ST  : BP_WNT;
      BP_ST:   next_s = taken ? BP_ST  : BP_WT;
      default: next_s = cnt;
    endcase
  end

  assign cnt_next = next_s;

endmodule

// File: rtl/branch_predictor.sv
// Bimodal branch predictor: ID-stage lookup, EX-stage resolve and training.
// Define BP_GSHARE_EN to XOR both indices with a non-speculative global history register.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int      ENTRIES     = BP_ENTRIES,
  parameter bp_cnt_t RESET_STATE = BP_ST
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ID_branch_i,
  input  logic [31:0] ID_pc_i,
  output logic        predict_o,
  input  logic        EX_branch_i,
  input  logic [31:0] EX_pc_i,
  input  logic        EX_taken_i,
  input  logic        EX_predict_i,
  output logic        predictWrong_o
);

  localparam int IDX_W = $clog2(ENTRIES);

  bp_cnt_t            cnt_r [ENTRIES];
  logic [IDX_W-1:0]   idx_rd_s;
  logic [IDX_W-1:0]   idx_wr_s;
  bp_cnt_t            cnt_wr_cur_s;
  bp_cnt_t            cnt_wr_next_s;
  logic               unused_pc_s;

`ifdef BP_GSHARE_EN
  logic [IDX_W-1:0]   ghr_r;
  logic [IDX_W-1:0]   ghr_next_s;

  assign idx_rd_s   = ID_pc_i[IDX_W+1:2] ^ ghr_r;
  assign idx_wr_s   = EX_pc_i[IDX_W+1:2] ^ ghr_r;
  // Shift form keeps the expression legal even when IDX_W is 1
  assign ghr_next_s = (ghr_r << 1) | IDX_W'(EX_taken_i);

  // Global history advances only on resolved branches, same edge as the counter
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ghr_r <= '0;
    end else if (EX_branch_i) begin
      ghr_r <= ghr_next_s;
    end else begin
      ghr_r <= ghr_r;
    end
  end
`else
  assign idx_rd_s = ID_pc_i[IDX_W+1:2];
  assign idx_wr_s = EX_pc_i[IDX_W+1:2];
`endif

  assign unused_pc_s = ^{ID_pc_i[31:IDX_W+2], ID_pc_i[1:0],
                         EX_pc_i[31:IDX_W+2], EX_pc_i[1:0]};

  assign predict_o      = ID_branch_i & cnt_r[idx_rd_s][1];
  assign predictWrong_o = EX_branch_i & (EX_predict_i ^ EX_taken_i);

  assign cnt_wr_cur_s = cnt_r[idx_wr_s];

  bp_sat_counter u_sat_counter (
    .cnt      (cnt_wr_cur_s),
    .taken    (EX_taken_i),
    .cnt_next (cnt_wr_next_s)
  );

  // Counter table: reload on reset, train the EX-indexed entry on each resolved branch
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        cnt_r[i] <= RESET_STATE;
      end
    end else if (EX_branch_i) begin
      cnt_r[idx_wr_s] <= cnt_wr_next_s;
    end else begin
      cnt_r[idx_wr_s] <= cnt_wr_cur_s;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (default PC-indexed build, 16 entries).
module tb_branch_predictor;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        ID_branch_i;
  logic [31:0] ID_pc_i;
  logic        predict_o;
  logic        EX_branch_i;
  logic [31:0] EX_pc_i;
  logic        EX_taken_i;
  logic        EX_predict_i;
  logic        predictWrong_o;

  int n_cmp = 0;
  int n_err = 0;

  branch_predictor dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .ID_branch_i    (ID_branch_i),
    .ID_pc_i        (ID_pc_i),
    .predict_o      (predict_o),
    .EX_branch_i    (EX_branch_i),
    .EX_pc_i        (EX_pc_i),
    .EX_taken_i     (EX_taken_i),
    .EX_predict_i   (EX_predict_i),
    .predictWrong_o (predictWrong_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge so inputs change away from it
  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic lookup(input logic [31:0] pc, input string tag, input logic exp);
    ID_branch_i = 1'b1;
    ID_pc_i     = pc;
    #1;
    chk(tag, predict_o, exp);
  endtask

  task automatic resolve(input logic [31:0] pc, input logic taken, input logic pred);
    EX_branch_i  = 1'b1;
    EX_pc_i      = pc;
    EX_taken_i   = taken;
    EX_predict_i = pred;
  endtask

  task automatic ex_idle();
    EX_branch_i  = 1'b0;
    EX_pc_i      = 32'h0;
    EX_taken_i   = 1'b0;
    EX_predict_i = 1'b0;
  endtask

  initial begin
    rst_i       = 1'b0;
    ID_branch_i = 1'b0;
    ID_pc_i     = 32'h0;
    ex_idle();
    #3;
    chk("rst_predict_idle", predict_o, 1'b0);
    chk("rst_wrong_idle", predictWrong_o, 1'b0);
    tick();
    rst_i = 1'b1;

    // Reset then lookup
    lookup(32'h40, "reset_lookup_40", 1'b1);
    ID_branch_i = 1'b0;
    #1;
    chk("no_branch_predict", predict_o, 1'b0);

    // Resolve with no EX branch never flags, even with mismatched predict/taken
    EX_branch_i = 1'b0; EX_predict_i = 1'b1; EX_taken_i = 1'b0;
    #1;
    chk("ex_bubble_no_wrong", predictWrong_o, 1'b0);

    // Train 0x40 down: 11 -> 10 -> 01 -> 00
    resolve(32'h40, 1'b0, 1'b1);
    #1; chk("down1_wrong", predictWrong_o, 1'b1);
    tick();
    lookup(32'h40, "down1_lookup_10", 1'b1);
    chk("down2_wrong", predictWrong_o, 1'b1);
    tick();
    lookup(32'h40, "down2_lookup_01", 1'b0);
    chk("down3_wrong", predictWrong_o, 1'b1);
    tick();
    ex_idle();
    lookup(32'h40, "down3_lookup_00", 1'b0);

    // Saturation at 00, then climb 00 -> 01 -> 10
    resolve(32'h40, 1'b0, 1'b0);
    #1; chk("sat_nt_no_wrong", predictWrong_o, 1'b0);
    tick(); tick();
    ex_idle();
    lookup(32'h40, "sat_stays_00", 1'b0);
    resolve(32'h40, 1'b1, 1'b0);
    #1; chk("up_wrong", predictWrong_o, 1'b1);
    tick();
    lookup(32'h40, "up1_lookup_01", 1'b0);
    tick();
    ex_idle();
    lookup(32'h40, "up2_lookup_10", 1'b1);

    // Same-cycle hazard on 0x44: bring it to 10, then lookup while resolving not-taken
    resolve(32'h44, 1'b0, 1'b1);
    tick();
    lookup(32'h44, "hazard_pre_update", 1'b1);
    tick();
    ex_idle();
    lookup(32'h44, "hazard_post_update", 1'b0);

    // Aliasing: 0x84 shares index 1 with 0x44 (now 01 -> 10); 0x80/0xC0/0x40 share index 0
    resolve(32'h84, 1'b1, 1'b0);
    tick();
    resolve(32'h80, 1'b0, 1'b1);
    tick(); tick();
    ex_idle();
    lookup(32'hC0, "alias_c0_trained", 1'b0);
    lookup(32'h40, "alias_40_trained", 1'b0);
    lookup(32'h84, "isolate_84", 1'b1);
    lookup(32'h83, "pc_low_bits_ignored", 1'b0);

    // Mid-stream asynchronous reset between clock edges
    lookup(32'h40, "pre_reset_lookup", 1'b0);
    rst_i = 1'b0;
    #1;
    chk("async_reset_lookup_40", predict_o, 1'b1);
    chk("async_reset_wrong", predictWrong_o, 1'b0);
    ID_pc_i = 32'h44;
    #1;
    chk("async_reset_lookup_44", predict_o, 1'b1);
    rst_i = 1'b1;
    tick();
    lookup(32'hC0, "post_reset_lookup_c0", 1'b1);
    ID_branch_i = 1'b0;
    #1;
    chk("post_reset_no_branch", predict_o, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench did not complete");
  end

endmodule
